// File: rtl/hash_table_pkg.sv
// Shared types and constants for the hash-table data path.
package hash_table_pkg;

   // Data-table address width; the table holds 2**TABLE_ADDR_WIDTH words.
   localparam int TABLE_ADDR_WIDTH = 4;
   localparam int KEY_WIDTH        = 16;
   localparam int VALUE_WIDTH      = 15;

   // One data-table word: occupancy flag, key and stored value.
   typedef struct packed {
      logic                   valid;
      logic [KEY_WIDTH-1:0]   key;
      logic [VALUE_WIDTH-1:0] value;
   } ram_data_t;

   // Arbitration mode encodings.
   localparam int ARB_FIXED = 0;   // highest asserted index wins
   localparam int ARB_RR    = 1;   // round-robin starting at the pointer

   // Clear-sweep controller states.
   typedef enum logic [0:0] {
      CLR_IDLE  = 1'b0,
      CLR_CLEAR = 1'b1
   } clear_state_t;

   // Width of an index into n entries, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ht_rr_arbiter.sv
// N-way request arbiter: fixed priority (highest index) or round-robin.
// Grant is combinational from req; the round-robin pointer moves past the
// winner whenever a grant is issued with advance high.
module ht_rr_arbiter
   import hash_table_pkg::*;
#(
   parameter int N    = 3,
   parameter int MODE = ARB_FIXED
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PW = idx_width(N);

   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] ptr_next;
   logic [N-1:0]  fix_gnt;
   logic [N-1:0]  rr_gnt;
   logic [PW-1:0] win_idx;

   // (base + off) mod N, kept in pointer width.
   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
      return PW'((int'(base) + off) % N);
   endfunction

   // Fixed priority: scan upward so the highest asserted request is kept.
   always_comb begin
      fix_gnt = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            fix_gnt = N'(1) << i;
         end
      end
   end

   // Round-robin: scan offsets downward so the request nearest the pointer is kept.
   always_comb begin
      rr_gnt = '0;
      for (int off = N - 1; off >= 0; off--) begin
         if (req[wrap_idx(ptr_reg, off)]) begin
            rr_gnt = N'(1) << wrap_idx(ptr_reg, off);
         end
      end
   end

   assign gnt = (MODE == ARB_RR) ? rr_gnt : fix_gnt;

   // Encode the one-hot grant and compute the pointer position after it.
   always_comb begin
      win_idx  = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            win_idx = PW'(i);
         end
      end
      ptr_next = ptr_reg;
      if (advance && (|gnt)) begin
         ptr_next = wrap_idx(win_idx, 1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/data_table_ram_ctrl.sv
// Access controller for the hash-table data RAM. Arbitrates engine reads and
// writes onto the RAM ports, tags each read so the returned word is flagged
// for its requester only, and runs the full-RAM clear sweep.
module data_table_ram_ctrl
   import hash_table_pkg::*;
#(
   parameter int DIR_CNT     = 3,
   parameter int A_WIDTH     = TABLE_ADDR_WIDTH,
   parameter int D_WIDTH     = $bits(ram_data_t),
   parameter int RAM_LATENCY = 2,
   parameter int ARB_MODE    = ARB_FIXED
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [DIR_CNT*A_WIDTH-1:0] rd_addr_i,
   input  logic [DIR_CNT-1:0]         rd_en_i,
   output logic [DIR_CNT-1:0]         rd_gnt_o,
   output logic [D_WIDTH-1:0]         rd_data_o,
   output logic [DIR_CNT-1:0]         rd_data_val_o,
   input  logic [DIR_CNT*A_WIDTH-1:0] wr_addr_i,
   input  logic [DIR_CNT*D_WIDTH-1:0] wr_data_i,
   input  logic [DIR_CNT-1:0]         wr_en_i,
   output logic [DIR_CNT-1:0]         wr_gnt_o,
   output logic [A_WIDTH-1:0]         ram_rd_addr_o,
   output logic                       ram_rd_en_o,
   input  logic [D_WIDTH-1:0]         ram_rd_data_i,
   output logic [A_WIDTH-1:0]         ram_wr_addr_o,
   output logic [D_WIDTH-1:0]         ram_wr_data_o,
   output logic                       ram_wr_en_o,
   input  logic                       clear_ram_run_i,
   output logic                       clear_busy_o,
   output logic                       clear_ram_done_o
);

   localparam int                 IW        = idx_width(DIR_CNT);
   localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

   clear_state_t         state_reg;
   clear_state_t         state_next;
   logic [A_WIDTH-1:0]   cnt_reg;
   logic [A_WIDTH-1:0]   cnt_next;
   logic                 done_reg;
   logic                 done_next;
   logic                 clearing;

   logic [DIR_CNT-1:0]   rd_req;
   logic [DIR_CNT-1:0]   wr_req;
   logic [DIR_CNT-1:0]   rd_gnt;
   logic [DIR_CNT-1:0]   wr_gnt;

   logic [A_WIDTH-1:0]   rd_addr_arr [DIR_CNT];
   logic [A_WIDTH-1:0]   wr_addr_arr [DIR_CNT];
   logic [D_WIDTH-1:0]   wr_data_arr [DIR_CNT];

   logic [A_WIDTH-1:0]   rd_addr_sel;
   logic [A_WIDTH-1:0]   wr_addr_sel;
   logic [D_WIDTH-1:0]   wr_data_sel;
   logic [IW-1:0]        rd_idx;

   logic [RAM_LATENCY-1:0] tag_val_reg;
   logic [IW-1:0]          tag_idx_reg [RAM_LATENCY];

   assign clearing = (state_reg == CLR_CLEAR);

   // Split the flat per-engine buses into one entry per engine.
   for (genvar gi = 0; gi < DIR_CNT; gi++) begin : g_unpack
      assign rd_addr_arr[gi] = rd_addr_i[gi*A_WIDTH +: A_WIDTH];
      assign wr_addr_arr[gi] = wr_addr_i[gi*A_WIDTH +: A_WIDTH];
      assign wr_data_arr[gi] = wr_data_i[gi*D_WIDTH +: D_WIDTH];
   end

   // The sweep owns both RAM ports, so no engine may win while it runs.
   assign rd_req = clearing ? '0 : rd_en_i;
   assign wr_req = clearing ? '0 : wr_en_i;

   ht_rr_arbiter #(
      .N    (DIR_CNT),
      .MODE (ARB_MODE)
   ) u_rd_arb (
      .clk     (clk_i),
      .rst     (rst_i),
      .req     (rd_req),
      .advance (~clearing),
      .gnt     (rd_gnt)
   );

   ht_rr_arbiter #(
      .N    (DIR_CNT),
      .MODE (ARB_MODE)
   ) u_wr_arb (
      .clk     (clk_i),
      .rst     (rst_i),
      .req     (wr_req),
      .advance (~clearing),
      .gnt     (wr_gnt)
   );

   // Select the granted engine's address/data; grants are one-hot so at most one hit.
   always_comb begin
      rd_addr_sel = '0;
      wr_addr_sel = '0;
      wr_data_sel = '0;
      rd_idx      = '0;
      for (int i = 0; i < DIR_CNT; i++) begin
         if (rd_gnt[i]) begin
            rd_addr_sel = rd_addr_arr[i];
            rd_idx      = IW'(i);
         end
         if (wr_gnt[i]) begin
            wr_addr_sel = wr_addr_arr[i];
            wr_data_sel = wr_data_arr[i];
         end
      end
   end

   assign rd_gnt_o      = rd_gnt;
   assign wr_gnt_o      = wr_gnt;
   assign ram_rd_en_o   = |rd_gnt;
   assign ram_rd_addr_o = rd_addr_sel;
   assign ram_wr_en_o   = clearing | (|wr_gnt);
   assign ram_wr_addr_o = clearing ? cnt_reg : wr_addr_sel;
   assign ram_wr_data_o = clearing ? '0 : wr_data_sel;

   // Read data is not registered here; the tag decides who may consume it.
   assign rd_data_o        = ram_rd_data_i;
   assign clear_busy_o     = clearing;
   assign clear_ram_done_o = done_reg;

   // Clear-sweep next state: a run pulse always (re)starts at address 0.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      case (state_reg)
         CLR_IDLE: begin
            if (clear_ram_run_i) begin
               state_next = CLR_CLEAR;
               cnt_next   = '0;
            end
         end
         CLR_CLEAR: begin
            if (clear_ram_run_i) begin
               cnt_next = '0;
            end else if (cnt_reg == LAST_ADDR) begin
               state_next = CLR_IDLE;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = CLR_IDLE;
         end
      endcase
   end

   // Clear-sweep state, address counter and done pulse registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= CLR_IDLE;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
      end
   end

   // Read tag pipeline, one stage per cycle of RAM read latency.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_val_reg <= '0;
         for (int s = 0; s < RAM_LATENCY; s++) begin
            tag_idx_reg[s] <= '0;
         end
      end else begin
         tag_val_reg[0] <= |rd_gnt;
         tag_idx_reg[0] <= rd_idx;
         for (int s = 1; s < RAM_LATENCY; s++) begin
            tag_val_reg[s] <= tag_val_reg[s-1];
            tag_idx_reg[s] <= tag_idx_reg[s-1];
         end
      end
   end

   // Decode the last tag stage into the one-hot data-valid vector.
   always_comb begin
      rd_data_val_o = '0;
      for (int i = 0; i < DIR_CNT; i++) begin
         rd_data_val_o[i] = tag_val_reg[RAM_LATENCY-1] && (tag_idx_reg[RAM_LATENCY-1] == IW'(i));
      end
   end

endmodule

// File: tb/tb_data_table_ram_ctrl.sv
// Bench for data_table_ram_ctrl: one instance per arbitration mode, each with
// its own behavioural RAM, checked every cycle against a transaction model.
module tb_data_table_ram_ctrl;
   import hash_table_pkg::*;

   localparam int N     = 3;
   localparam int AW    = TABLE_ADDR_WIDTH;
   localparam int DW    = $bits(ram_data_t);
   localparam int LAT   = 2;
   localparam int DEPTH = 1 << AW;
   localparam int AWT   = N * AW;
   localparam int DWT   = N * DW;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   logic [AWT-1:0] rd_addr = '0;
   logic [AWT-1:0] wr_addr = '0;
   logic [DWT-1:0] wr_data = '0;
   logic [N-1:0]   rd_en = '0;
   logic [N-1:0]   wr_en = '0;
   logic           clear_run = 1'b0;

   logic [N-1:0]  rd_gnt      [2];
   logic [N-1:0]  wr_gnt      [2];
   logic [N-1:0]  rd_val      [2];
   logic [DW-1:0] rd_data     [2];
   logic [AW-1:0] ram_rd_addr [2];
   logic          ram_rd_en   [2];
   logic [DW-1:0] ram_rd_data [2];
   logic [AW-1:0] ram_wr_addr [2];
   logic [DW-1:0] ram_wr_data [2];
   logic          ram_wr_en   [2];
   logic          busy        [2];
   logic          done        [2];

   // Instance gi uses ARB_MODE = gi, backed by a read-first RAM of latency LAT.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] rdq [LAT];

      data_table_ram_ctrl #(
         .DIR_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(LAT), .ARB_MODE(gi)
      ) u_dut (
         .clk_i(clk), .rst_i(rst_i),
         .rd_addr_i(rd_addr), .rd_en_i(rd_en), .rd_gnt_o(rd_gnt[gi]),
         .rd_data_o(rd_data[gi]), .rd_data_val_o(rd_val[gi]),
         .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_en_i(wr_en), .wr_gnt_o(wr_gnt[gi]),
         .ram_rd_addr_o(ram_rd_addr[gi]), .ram_rd_en_o(ram_rd_en[gi]),
         .ram_rd_data_i(ram_rd_data[gi]),
         .ram_wr_addr_o(ram_wr_addr[gi]), .ram_wr_data_o(ram_wr_data[gi]),
         .ram_wr_en_o(ram_wr_en[gi]),
         .clear_ram_run_i(clear_run), .clear_busy_o(busy[gi]),
         .clear_ram_done_o(done[gi])
      );

      always @(posedge clk) begin
         if (ram_wr_en[gi]) mem[ram_wr_addr[gi]] <= ram_wr_data[gi];
         rdq[0] <= ram_rd_en[gi] ? mem[ram_rd_addr[gi]] : '0;
         for (int k = 1; k < LAT; k++) rdq[k] <= rdq[k-1];
      end
      assign ram_rd_data[gi] = rdq[LAT-1];
   end

   // ---------------- reference model ----------------
   int            rd_ptr [2];
   int            wr_ptr [2];
   int            pend_eng [2][LAT];
   logic [DW-1:0] pend_word [2][LAT];
   logic [DW-1:0] ref_mem [2][DEPTH];
   bit            clr_on;
   int            clr_cnt;
   bit            done_exp;

   int n_checks = 0;
   int n_pass   = 0;
   int done_seen = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Winner among req: highest index (mode 0) or first at/after ptr (mode 1); -1 if none.
   function automatic int pick(input logic [N-1:0] req, input int mode, input int ptr);
      if (mode == 0) begin
         for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
      end else begin
         for (int off = 0; off < N; off++) if (req[(ptr + off) % N]) return (ptr + off) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         rd_ptr[m] = 0;
         wr_ptr[m] = 0;
         for (int s = 0; s < LAT; s++) begin
            pend_eng[m][s]  = -1;
            pend_word[m][s] = '0;
         end
      end
      clr_on   = 1'b0;
      clr_cnt  = 0;
      done_exp = 1'b0;
   endtask

   task automatic rand_inputs();
      rd_en   = N'($urandom);
      wr_en   = N'($urandom);
      rd_addr = AWT'($urandom);
      wr_addr = AWT'($urandom);
      for (int e = 0; e < N; e++) wr_data[e*DW +: DW] = DW'($urandom);
   endtask

   // Compare every DUT output against the model, mid-cycle.
   task automatic check_cycle();
      int rw;
      int ww;
      int pe;
      #3;
      if (done[0]) done_seen++;
      for (int m = 0; m < 2; m++) begin
         rw = clr_on ? -1 : pick(rd_en, m, rd_ptr[m]);
         ww = clr_on ? -1 : pick(wr_en, m, wr_ptr[m]);
         check_eq($sformatf("m%0d.rd_gnt", m), 64'(rd_gnt[m]), 64'(onehot(rw)));
         check_eq($sformatf("m%0d.wr_gnt", m), 64'(wr_gnt[m]), 64'(onehot(ww)));
         check_eq($sformatf("m%0d.ram_rd_en", m), 64'(ram_rd_en[m]), 64'(rw >= 0));
         if (rw >= 0)
            check_eq($sformatf("m%0d.ram_rd_addr", m), 64'(ram_rd_addr[m]), 64'(rd_addr[rw*AW +: AW]));
         check_eq($sformatf("m%0d.ram_wr_en", m), 64'(ram_wr_en[m]), 64'(clr_on || ww >= 0));
         if (clr_on) begin
            check_eq($sformatf("m%0d.clr_addr", m), 64'(ram_wr_addr[m]), 64'(clr_cnt));
            check_eq($sformatf("m%0d.clr_data", m), 64'(ram_wr_data[m]), 64'(0));
         end else if (ww >= 0) begin
            check_eq($sformatf("m%0d.ram_wr_addr", m), 64'(ram_wr_addr[m]), 64'(wr_addr[ww*AW +: AW]));
            check_eq($sformatf("m%0d.ram_wr_data", m), 64'(ram_wr_data[m]), 64'(wr_data[ww*DW +: DW]));
         end
         check_eq($sformatf("m%0d.busy", m), 64'(busy[m]), 64'(clr_on));
         check_eq($sformatf("m%0d.done", m), 64'(done[m]), 64'(done_exp));
         pe = pend_eng[m][LAT-1];
         check_eq($sformatf("m%0d.rd_val", m), 64'(rd_val[m]), 64'(onehot(pe)));
         if (pe >= 0)
            check_eq($sformatf("m%0d.rd_data", m), 64'(rd_data[m]), 64'(pend_word[m][LAT-1]));
      end
   endtask

   // Apply this cycle's transactions to the model, then move to the next cycle.
   task automatic advance();
      int rw;
      int ww;
      logic [DW-1:0] word;
      for (int m = 0; m < 2; m++) begin
         rw = clr_on ? -1 : pick(rd_en, m, rd_ptr[m]);
         ww = clr_on ? -1 : pick(wr_en, m, wr_ptr[m]);
         word = (rw >= 0) ? ref_mem[m][rd_addr[rw*AW +: AW]] : '0;
         for (int s = LAT - 1; s > 0; s--) begin
            pend_eng[m][s]  = pend_eng[m][s-1];
            pend_word[m][s] = pend_word[m][s-1];
         end
         pend_eng[m][0]  = rw;
         pend_word[m][0] = word;
         if (clr_on) ref_mem[m][clr_cnt] = '0;
         else if (ww >= 0) ref_mem[m][wr_addr[ww*AW +: AW]] = wr_data[ww*DW +: DW];
         if (m == 1 && rw >= 0) rd_ptr[m] = (rw + 1) % N;
         if (m == 1 && ww >= 0) wr_ptr[m] = (ww + 1) % N;
      end
      done_exp = 1'b0;
      if (clear_run) begin
         clr_on  = 1'b1;
         clr_cnt = 0;
      end else if (clr_on) begin
         if (clr_cnt == DEPTH - 1) begin
            clr_on   = 1'b0;
            done_exp = 1'b1;
         end else begin
            clr_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      check_cycle();
      advance();
   endtask

   task automatic quiet();
      rd_en = '0;
      wr_en = '0;
      clear_run = 1'b0;
   endtask

   logic [N-1:0]  rr_seq [4];
   logic [DW-1:0] w0;
   logic [DW-1:0] w2;

   initial begin
      for (int m = 0; m < 2; m++)
         for (int a = 0; a < DEPTH; a++) ref_mem[m][a] = '0;
      model_reset();
      rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;

      // Reset state
      #3;
      for (int m = 0; m < 2; m++) begin
         check_eq("rst.busy", 64'(busy[m]), 64'(0));
         check_eq("rst.done", 64'(done[m]), 64'(0));
         check_eq("rst.rd_val", 64'(rd_val[m]), 64'(0));
         check_eq("rst.ram_rd_en", 64'(ram_rd_en[m]), 64'(0));
         check_eq("rst.ram_wr_en", 64'(ram_wr_en[m]), 64'(0));
         check_eq("rst.rd_gnt", 64'(rd_gnt[m]), 64'(0));
      end
      @(posedge clk);
      #1;
      rst_i = 1'b0;

      // Full clear sweep with write requests pending throughout
      clear_run = 1'b1;
      cycle();
      clear_run = 1'b0;
      done_seen = 0;
      for (int i = 1; i <= 18; i++) begin
         wr_en   = N'($urandom) | 3'b001;
         wr_addr = AWT'($urandom);
         check_cycle();
         if (i <= 16) check_eq("clr.wr_gnt_blocked", 64'(wr_gnt[0]), 64'(0));
         if (i == 17) check_eq("clr.done_cycle17", 64'(done[0]), 64'(1));
         advance();
      end
      check_eq("clr.done_count", 64'(done_seen), 64'(1));
      quiet();

      // Round-robin sequence with all three engines requesting
      rd_en = 3'b111;
      for (int i = 0; i < 4; i++) begin
         rd_addr = AWT'($urandom);
         check_cycle();
         check_eq($sformatf("rr.seq%0d", i), 64'(rd_gnt[1]), 64'(rr_seq[i]));
         advance();
      end
      quiet();
      cycle();
      cycle();

      // Fixed priority: engine 2 wins, its tag returns two cycles later
      rd_en   = 3'b111;
      rd_addr = {4'd7, 4'd6, 4'd5};
      check_cycle();
      check_eq("fix.gnt", 64'(rd_gnt[0]), 64'(3'b100));
      check_eq("fix.addr", 64'(ram_rd_addr[0]), 64'(7));
      advance();
      quiet();
      cycle();
      check_cycle();
      check_eq("fix.val", 64'(rd_val[0]), 64'(3'b100));
      advance();

      // Back-to-back reads by engines 0 and 2 of freshly written words
      w0 = DW'($urandom);
      w2 = DW'($urandom) ^ 32'h5a5a_0001;
      wr_en = 3'b001; wr_addr = AWT'(3); wr_data[0 +: DW] = w0;
      cycle();
      wr_en = 3'b100; wr_addr = {4'd12, 8'd0}; wr_data[2*DW +: DW] = w2;
      cycle();
      quiet();
      rd_en = 3'b001; rd_addr = AWT'(3);
      cycle();
      rd_en = 3'b100; rd_addr = {4'd12, 8'd0};
      cycle();
      quiet();
      check_cycle();
      for (int m = 0; m < 2; m++) begin
         check_eq("b2b.val0", 64'(rd_val[m]), 64'(3'b001));
         check_eq("b2b.data0", 64'(rd_data[m]), 64'(w0));
      end
      advance();
      check_cycle();
      for (int m = 0; m < 2; m++) begin
         check_eq("b2b.val2", 64'(rd_val[m]), 64'(3'b100));
         check_eq("b2b.data2", 64'(rd_data[m]), 64'(w2));
      end
      advance();

      // Restart the sweep at address 9: one done pulse, 17 cycles after restart
      done_seen = 0;
      clear_run = 1'b1;
      cycle();
      clear_run = 1'b0;
      for (int i = 0; i < 9; i++) cycle();
      clear_run = 1'b1;
      check_cycle();
      check_eq("restart.at_addr9", 64'(ram_wr_addr[0]), 64'(9));
      advance();
      clear_run = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         wr_en = N'($urandom);
         check_cycle();
         if (i == 17) check_eq("restart.done_cycle17", 64'(done[0]), 64'(1));
         advance();
      end
      check_eq("restart.done_count", 64'(done_seen), 64'(1));
      quiet();

      // Randomized traffic with occasional clear pulses
      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         clear_run = ($urandom_range(0, 99) < 2);
         cycle();
      end
      quiet();
      for (int i = 0; i < 20; i++) cycle();

      // Reset in the middle of a sweep
      clear_run = 1'b1;
      cycle();
      clear_run = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      #2;
      rst_i = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) begin
         check_eq("midrst.busy", 64'(busy[m]), 64'(0));
         check_eq("midrst.done", 64'(done[m]), 64'(0));
         check_eq("midrst.rd_val", 64'(rd_val[m]), 64'(0));
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         rand_inputs();
         cycle();
      end
      check_eq("midrst.no_done", 64'(done_seen), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
